choose_cursor_ctrl: RTL and testbench

- Produces the `pokemon_id` cursor that the choose-scene renderer consumes. The renderer reads the cursor; this block writes it.
- Converts debounced button levels into cursor moves over the 2x4 selection grid.
- Updates the cursor only at frame boundaries so the highlight frame never tears mid-scan.
- Hands the confirmed choice to the game FSM over a valid/ready handshake.

---
 rtl/choose_cursor_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_choose_cursor_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/choose_cursor_ctrl.sv
// choose_cursor_ctrl
// Cursor controller for the choose scene. It turns debounced button levels
// into moves over a 2x4 selection grid and updates the cursor only at frame
// boundaries. The confirmed choice goes to the game FSM over a valid/ready
// handshake.
//
// Optional feature: define CHOOSE_CURSOR_AUTO_REPEAT_EN to add per-direction
// auto-repeat. A held direction then injects an extra move every
// REPEAT_FRAMES frames. In the default build no repeat counters exist.
//
// Grid mapping: id = row*4 + col + 1. The zero-based index id-1 therefore
// splits into {row, col[1:0]}, which makes wrap-around free in 2-bit and
// 1-bit arithmetic.
module choose_cursor_ctrl #(
  parameter logic [7:0] INIT_ID       = 8'd1,
  parameter int         REPEAT_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  output logic [7:0] pokemon_id,
  output logic       sel_valid,
  output logic [7:0] sel_id,
  input  logic       sel_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BROWSE = 2'd1,
    S_OFFER  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Button vector bit order: 0 up, 1 down, 2 left, 3 right, 4 confirm, 5 cancel
  localparam int B_UP      = 0;
  localparam int B_DOWN    = 1;
  localparam int B_LEFT    = 2;
  localparam int B_RIGHT   = 3;
  localparam int B_CONFIRM = 4;
  localparam int B_CANCEL  = 5;

  state_t      state;
  logic [5:0]  btn_vec;
  logic [5:0]  prev_level;
  logic [5:0]  press;
  logic [4:0]  pending;
  logic [3:0]  rep_press;
  logic [3:0]  eff_dir;
  logic        eff_confirm;
  logic [2:0]  cur_idx;
  logic        row_next;
  logic [1:0]  col_next;
  logic [7:0]  next_id;
  logic        in_browse;

  assign btn_vec   = {btn_cancel, btn_confirm, btn_right, btn_left, btn_down, btn_up};
  assign press     = btn_vec & ~prev_level;
  assign in_browse = (state == S_BROWSE);

  // Previous levels reset high, so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level <= '1;
    end else begin
      prev_level <= btn_vec;
    end
  end

  // Sticky per-frame press accumulation, valid only while browsing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (!in_browse || frame_start) begin
      pending <= '0;
    end else begin
      pending <= pending | press[4:0];
    end
  end

`ifdef CHOOSE_CURSOR_AUTO_REPEAT_EN
  localparam int         CW       = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_FRAMES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_repeat
      logic [CW-1:0] frame_cnt;

      // Count frames with this direction held; wrap and fire on the last one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          frame_cnt <= '0;
        end else if (!in_browse || !btn_vec[gi]) begin
          frame_cnt <= '0;
        end else if (frame_start) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end

      assign rep_press[gi] = in_browse && btn_vec[gi] && frame_start &&
                             (frame_cnt == CNT_LAST);
    end
  endgenerate
`else
  assign rep_press = '0;
`endif

  // A press landing on the frame_start cycle itself still counts for that frame
  assign eff_dir     = pending[3:0] | press[3:0] | rep_press;
  assign eff_confirm = pending[B_CONFIRM] | press[B_CONFIRM];

  // Next cursor position from the pending moves of this frame
  always_comb begin
    cur_idx  = 3'(pokemon_id - 8'd1);
    row_next = cur_idx[2];
    col_next = cur_idx[1:0];
    if (eff_dir[B_LEFT] && !eff_dir[B_RIGHT]) begin
      col_next = cur_idx[1:0] - 2'd1;
    end else if (eff_dir[B_RIGHT] && !eff_dir[B_LEFT]) begin
      col_next = cur_idx[1:0] + 2'd1;
    end
    if (eff_dir[B_UP] ^ eff_dir[B_DOWN]) begin
      row_next = ~cur_idx[2];
    end
    next_id = {5'd0, row_next, col_next} + 8'd1;
  end

  // Scene FSM with registered cursor, selection and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pokemon_id <= INIT_ID;
      sel_valid  <= 1'b0;
      sel_id     <= 8'd0;
      busy       <= 1'b0;
    end else if (!enable) begin
      state     <= S_IDLE;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_BROWSE;
          busy  <= 1'b0;
        end
        S_BROWSE: begin
          if (frame_start) begin
            if (eff_confirm) begin
              sel_id    <= pokemon_id;
              sel_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= S_OFFER;
            end else begin
              pokemon_id <= next_id;
            end
          end
        end
        S_OFFER: begin
          // Handshake takes priority over a simultaneous cancel
          if (sel_ready) begin
            sel_valid <= 1'b0;
            state     <= S_DONE;
          end else if (press[B_CANCEL]) begin
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_BROWSE;
          end
        end
        S_DONE: begin
          sel_valid <= 1'b0;
          busy      <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_choose_cursor_ctrl.sv
// Directed testbench for choose_cursor_ctrl.
module tb_choose_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       frame_start;
  logic       btn_up, btn_down, btn_left, btn_right, btn_confirm, btn_cancel;
  logic [7:0] pokemon_id;
  logic       sel_valid;
  logic [7:0] sel_id;
  logic       sel_ready;
  logic       busy;

  int cmp_n = 0;
  int err_n = 0;
  int hs_count = 0;

  choose_cursor_ctrl #(.INIT_ID(8'd1), .REPEAT_FRAMES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_confirm (btn_confirm),
    .btn_cancel  (btn_cancel),
    .pokemon_id  (pokemon_id),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .sel_ready   (sel_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sel_valid && sel_ready) hs_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 confirm, 5 cancel
  task automatic set_btns(input logic [5:0] v);
    btn_up      = v[0];
    btn_down    = v[1];
    btn_left    = v[2];
    btn_right   = v[3];
    btn_confirm = v[4];
    btn_cancel  = v[5];
  endtask

  // Press then release, checking the cursor does not move on these cycles
  task automatic press(input logic [5:0] v, input string name);
    logic [7:0] held;
    held = pokemon_id;
    set_btns(v);
    tick();
    set_btns(6'b0);
    cmp_n++;
    if (pokemon_id !== held) begin
      err_n++;
      $display("FAIL %s_no_move_on_press: pokemon_id=%0d expected=%0d", name, pokemon_id, held);
    end
    tick();
    cmp_n++;
    if (pokemon_id !== held) begin
      err_n++;
      $display("FAIL %s_no_move_after_release: pokemon_id=%0d expected=%0d", name, pokemon_id, held);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; sel_ready = 1'b0;
    set_btns(6'b001000);
    repeat (3) tick();
    cmp_n++;
    if (pokemon_id !== 8'd1 || sel_valid !== 1'b0 || sel_id !== 8'd0 || busy !== 1'b0) begin
      err_n++;
      $display("FAIL reset_state: id=%0d valid=%b sel_id=%0d busy=%b expected 1/0/0/0",
               pokemon_id, sel_valid, sel_id, busy);
    end
    rst_n = 1'b1;
    tick(); tick();
    repeat (3) begin
      frame();
      tick();
    end
    cmp_n++;
    if (pokemon_id !== 8'd1) begin
      err_n++;
      $display("FAIL reset_held_button: pokemon_id=%0d expected=1", pokemon_id);
    end
    set_btns(6'b0);
    tick();
    $display("test_reset done: pokemon_id=%0d", pokemon_id);
  endtask

  task automatic test_moves();
    press(6'b000100, "left");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd4) begin
      err_n++; $display("FAIL move_left_wrap: pokemon_id=%0d expected=4", pokemon_id);
    end
    press(6'b000010, "down");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd8) begin
      err_n++; $display("FAIL move_down: pokemon_id=%0d expected=8", pokemon_id);
    end
    press(6'b001000, "right");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd5) begin
      err_n++; $display("FAIL move_right_wrap: pokemon_id=%0d expected=5", pokemon_id);
    end
    $display("test_moves done: pokemon_id=%0d", pokemon_id);
  endtask

  task automatic test_conflict();
    press(6'b001100, "lr");
    press(6'b000001, "up");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd1) begin
      err_n++; $display("FAIL lr_cancel_row_only: pokemon_id=%0d expected=1", pokemon_id);
    end
    press(6'b000011, "ud");
    press(6'b000100, "left2");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd4) begin
      err_n++; $display("FAIL ud_cancel_col_only: pokemon_id=%0d expected=4", pokemon_id);
    end
    press(6'b000010, "down2");
    press(6'b001000, "right2");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd5) begin
      err_n++; $display("FAIL combined_move: pokemon_id=%0d expected=5", pokemon_id);
    end
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd5) begin
      err_n++; $display("FAIL pending_cleared: pokemon_id=%0d expected=5", pokemon_id);
    end
    press(6'b001000, "right3");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd6) begin
      err_n++; $display("FAIL move_to_6: pokemon_id=%0d expected=6", pokemon_id);
    end
    $display("test_conflict done: pokemon_id=%0d", pokemon_id);
  endtask

  task automatic test_confirm();
    press(6'b010000, "confirm");
    frame();
    cmp_n++;
    if (sel_valid !== 1'b1 || sel_id !== 8'd6 || busy !== 1'b1) begin
      err_n++;
      $display("FAIL offer_entry: valid=%b sel_id=%0d busy=%b expected 1/6/1", sel_valid, sel_id, busy);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) frame_start = 1'b1;
      press(6'b001000, "offer_wait");
      frame_start = 1'b0;
      cmp_n++;
      if (sel_valid !== 1'b1 || sel_id !== 8'd6 || pokemon_id !== 8'd6) begin
        err_n++;
        $display("FAIL offer_hold_%0d: valid=%b sel_id=%0d id=%0d expected 1/6/6",
                 i, sel_valid, sel_id, pokemon_id);
      end
    end
    sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;
    cmp_n++;
    if (sel_valid !== 1'b0 || busy !== 1'b1 || sel_id !== 8'd6 || hs_count !== 1) begin
      err_n++;
      $display("FAIL handshake_done: valid=%b busy=%b sel_id=%0d hs=%0d expected 0/1/6/1",
               sel_valid, busy, sel_id, hs_count);
    end
    enable = 1'b0;
    tick();
    cmp_n++;
    if (busy !== 1'b0 || sel_valid !== 1'b0 || pokemon_id !== 8'd6) begin
      err_n++;
      $display("FAIL idle_after_disable: busy=%b valid=%b id=%0d expected 0/0/6", busy, sel_valid, pokemon_id);
    end
    $display("test_confirm done: sel_id=%0d hs=%0d", sel_id, hs_count);
  endtask

  task automatic test_cancel();
    enable = 1'b1;
    tick();
    press(6'b010000, "confirm_a");
    frame();
    cmp_n++;
    if (sel_valid !== 1'b1 || sel_id !== 8'd6) begin
      err_n++; $display("FAIL cancel_offer_a: valid=%b sel_id=%0d expected 1/6", sel_valid, sel_id);
    end
    btn_cancel = 1'b1;
    tick();
    btn_cancel = 1'b0;
    cmp_n++;
    if (sel_valid !== 1'b0 || busy !== 1'b0) begin
      err_n++; $display("FAIL cancel_to_browse: valid=%b busy=%b expected 0/0", sel_valid, busy);
    end
    tick();
    press(6'b000001, "up_after_cancel");
    frame();
    cmp_n++;
    if (pokemon_id !== 8'd2) begin
      err_n++; $display("FAIL browse_after_cancel: pokemon_id=%0d expected=2", pokemon_id);
    end
    press(6'b010000, "confirm_b");
    frame();
    cmp_n++;
    if (sel_valid !== 1'b1 || sel_id !== 8'd2) begin
      err_n++; $display("FAIL cancel_offer_b: valid=%b sel_id=%0d expected 1/2", sel_valid, sel_id);
    end
    btn_cancel = 1'b1;
    sel_ready = 1'b1;
    tick();
    btn_cancel = 1'b0;
    tick(); tick();
    sel_ready = 1'b0;
    cmp_n++;
    if (sel_valid !== 1'b0 || busy !== 1'b1 || hs_count !== 2 || sel_id !== 8'd2) begin
      err_n++;
      $display("FAIL cancel_vs_ready: valid=%b busy=%b hs=%0d sel_id=%0d expected 0/1/2/2",
               sel_valid, busy, hs_count, sel_id);
    end
    $display("test_cancel done: hs=%0d", hs_count);
  endtask

  task automatic test_reset_in_offer();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    press(6'b010000, "confirm_c");
    frame();
    cmp_n++;
    if (sel_valid !== 1'b1) begin
      err_n++; $display("FAIL offer_before_reset: valid=%b expected 1", sel_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp_n++;
    if (sel_valid !== 1'b0 || busy !== 1'b0 || pokemon_id !== 8'd1) begin
      err_n++;
      $display("FAIL async_reset_offer: valid=%b busy=%b id=%0d expected 0/0/1", sel_valid, busy, pokemon_id);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    $display("test_reset_in_offer done: pokemon_id=%0d", pokemon_id);
  endtask

`ifdef CHOOSE_CURSOR_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic [7:0] exp_id;
    btn_right = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      frame();
      exp_id = (k < 4) ? 8'd2 : ((k < 8) ? 8'd3 : 8'd4);
      cmp_n++;
      if (pokemon_id !== exp_id) begin
        err_n++; $display("FAIL auto_repeat_frame_%0d: pokemon_id=%0d expected=%0d", k, pokemon_id, exp_id);
      end
      tick();
    end
    btn_right = 1'b0;
    tick();
    $display("test_auto_repeat done: pokemon_id=%0d", pokemon_id);
  endtask
`endif

  initial begin
    test_reset();
    test_moves();
    test_conflict();
    test_confirm();
    test_cancel();
    test_reset_in_offer();
`ifdef CHOOSE_CURSOR_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
